mini_calc_issuer: RTL and testbench
===================================

MINI_CALC_ISSUER -- requirements
Module: mini_calc_issuer

Interface
REQ-001 The block SHALL have parameter INPUT_BIT_WIDTH, default 8, the operand and result width.
REQ-002 The block SHALL have parameter INSTR_BIT_WIDTH, default 4, the opcode width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, the number of command FIFO entries (power of two).
REQ-004 The block SHALL have parameter CALC_LATENCY, default 2, the number of cycles the calculator inputs are held before results are sampled (at least 1).
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Port Clk, input, 1 bit: the clock; all state updates on rising edge.
REQ-007 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Ports CmdValid/CmdReady, input/output, 1 bit each: the command handshake.
REQ-009 Ports CmdInstr, CmdA and CmdB, inputs, INSTR/INPUT/INPUT widths: the command opcode and operands.
REQ-010 Ports CalcInstruction, CalcInputA and CalcInputB, outputs, INSTR/INPUT/INPUT widths: drive the MiniCalc inputs.
REQ-011 Ports CalcOutputA and CalcOutputB, inputs, INPUT_BIT_WIDTH each: the MiniCalc results.
REQ-012 Ports ResValid/ResReady, output/input, 1 bit each: the result handshake.
REQ-013 Ports ResA, ResB (INPUT_BIT_WIDTH each), ResInstr (INSTR_BIT_WIDTH) and ResError (1 bit), outputs: the result payload.
REQ-014 Port Busy, output, 1 bit: high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-015 The block SHALL accept a command on a rising edge where CmdValid and CmdReady are both high, and CmdReady SHALL equal "FIFO not full".
REQ-016 When a push and a pop occur in the same cycle, the FIFO occupancy SHALL be unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESULT.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop the head and go to ISSUE next cycle; with the FIFO empty it SHALL remain in IDLE.
REQ-019 A legal opcode SHALL be one of NOP 1111, ADD_SUB 0111, MIN_MAX 1011, MUL 1101 or DIV 1110.
REQ-020 In ISSUE with a legal opcode, the block SHALL drive the Calc ports with the popped command and go to WAIT.
REQ-021 In ISSUE with an illegal opcode, the block SHALL not drive the Calc ports (they stay at NOP/0) and SHALL go to RESULT with ResError=1, ResA=ResB=0.
REQ-022 In WAIT, the block SHALL hold the Calc ports for CALC_LATENCY cycles counted from ISSUE, sample CalcOutputA/B on the final cycle into ResA/ResB, and go to RESULT.
REQ-023 In RESULT, ResValid SHALL be 1 and the payload SHALL stay stable until ResReady=1; on that handshake the FSM SHALL go to IDLE.
REQ-024 End-to-end latency from pop to ResValid SHALL be 1+CALC_LATENCY cycles for a legal opcode and 1 cycle for an illegal one.
REQ-025 Outside ISSUE/WAIT, CalcInstruction SHALL be NOP (1111) and CalcInputA/B SHALL be 0.
REQ-026 NOP commands SHALL be issued normally and return the sampled results; results SHALL pass through unmodified, with no special case for divide by zero.
REQ-027 ResInstr SHALL echo the opcode of the command that produced the result.
REQ-028 Commands SHALL complete strictly in FIFO order, with exactly one in flight.

Reset
REQ-029 Reset SHALL force the FSM to IDLE, empty the FIFO, and clear the latency counter.
REQ-030 During reset: CmdReady=0, ResValid=0, ResA=ResB=0, ResInstr=NOP, ResError=0, Busy=0, Calc ports at NOP/0.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight command and all queued commands, producing no result.
REQ-032 CmdReady SHALL be 1 from the first cycle after reset deasserts.

Structure
REQ-033 Package mini_calc_pkg SHALL hold the opcode constants, default widths and FSM state encoding, shared with MiniCalc and its bench.
REQ-034 The FIFO SHALL be a sub-module named mini_calc_cmd_fifo, with push/pop/full/empty and DEPTH/WIDTH parameters.

Verification
REQ-035 ADD_SUB 6,3 -> ResA=9, ResB=3 (ResValid 3 cycles after pop); then ADD_SUB 8,5 -> 13,3.
REQ-036 MIN_MAX 3,11 -> 11,3; MUL 6,3 -> 18,0; DIV 15,2 -> 7,1; NOP 6,3 -> 0,0, in order, with ResInstr matching each.
REQ-037 Five back-to-back pushes with ResReady=0 -> CmdReady low after the 4th+1 held; releasing ResReady drains all in order.
REQ-038 Opcode 0000 with 1,2 -> ResError=1, ResA=ResB=0, CalcInstruction stays 1111 throughout.
REQ-039 ResReady held low 10 cycles -> payload stable and ResValid high for all 10 cycles.
REQ-040 Reset pulsed during WAIT with 2 commands queued -> all outputs at reset values, no ResValid afterwards, Busy=0.

Source files
------------

// File: rtl/mini_calc_pkg.sv
// mini_calc_pkg: opcodes, default widths and FSM encoding shared by the issuer, MiniCalc and benches
package mini_calc_pkg;
  localparam int DEF_INPUT_BIT_WIDTH = 8;
  localparam int DEF_INSTR_BIT_WIDTH = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CALC_LATENCY = 2;
  localparam logic [3:0] OP_NOP = 4'b1111;
  localparam logic [3:0] OP_ADD_SUB = 4'b0111;
  localparam logic [3:0] OP_MIN_MAX = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1101;
  localparam logic [3:0] OP_DIV = 4'b1110;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;
endpackage

// File: rtl/mini_calc_cmd_fifo.sv
// mini_calc_cmd_fifo: command queue (power-of-two DEPTH entries of WIDTH bits)
// clk/rst: clock, async active-high reset; push/din: write; pop/dout: read head;
// full/empty: occupancy flags. Push when full and pop when empty are ignored.
module mini_calc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign wr = push & ~full;
  assign rd = pop & ~empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      if (wr != rd) cnt <= wr ? cnt + 1'b1 : cnt - 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/mini_calc_issuer.sv
// mini_calc_issuer: queues calculator commands and issues them one at a time to MiniCalc
// Clk/Reset: clock, async active-high reset
// CmdValid/CmdReady/CmdInstr/CmdA/CmdB: command input handshake and payload
// CalcInstruction/CalcInputA/CalcInputB: MiniCalc inputs; CalcOutputA/CalcOutputB: its results
// ResValid/ResReady/ResA/ResB/ResInstr/ResError: result handshake and payload
// Busy: FSM not idle or commands queued
module mini_calc_issuer
  import mini_calc_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = DEF_INPUT_BIT_WIDTH,
  parameter int INSTR_BIT_WIDTH = DEF_INSTR_BIT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CALC_LATENCY = DEF_CALC_LATENCY
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       CmdValid,
  output logic                       CmdReady,
  input  logic [INSTR_BIT_WIDTH-1:0] CmdInstr,
  input  logic [INPUT_BIT_WIDTH-1:0] CmdA,
  input  logic [INPUT_BIT_WIDTH-1:0] CmdB,
  output logic [INSTR_BIT_WIDTH-1:0] CalcInstruction,
  output logic [INPUT_BIT_WIDTH-1:0] CalcInputA,
  output logic [INPUT_BIT_WIDTH-1:0] CalcInputB,
  input  logic [INPUT_BIT_WIDTH-1:0] CalcOutputA,
  input  logic [INPUT_BIT_WIDTH-1:0] CalcOutputB,
  output logic                       ResValid,
  input  logic                       ResReady,
  output logic [INPUT_BIT_WIDTH-1:0] ResA,
  output logic [INPUT_BIT_WIDTH-1:0] ResB,
  output logic [INSTR_BIT_WIDTH-1:0] ResInstr,
  output logic                       ResError,
  output logic                       Busy
);
  localparam int W = INPUT_BIT_WIDTH;
  localparam int I = INSTR_BIT_WIDTH;
  localparam int FW = I + 2 * W;
  localparam int CW = $clog2(CALC_LATENCY + 1);
  localparam logic [I-1:0] NOP = I'(OP_NOP);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] cmd, cmd_n, head;
  logic [W-1:0] res_a_n, res_b_n, a, b;
  logic [I-1:0] res_instr_n, op;
  logic res_err_n, full, empty, push, pop, drive, legal;
  assign {op, a, b} = cmd;
  assign legal = op == NOP || op == I'(OP_ADD_SUB) || op == I'(OP_MIN_MAX) ||
                 op == I'(OP_MUL) || op == I'(OP_DIV);
  // Reset is folded in so the queue advertises no space while reset is held.
  assign CmdReady = ~full & ~Reset;
  assign push = CmdValid & CmdReady;
  assign ResValid = state == RESULT;
  assign Busy = state != IDLE || ~empty;
  assign CalcInstruction = drive ? op : NOP;
  assign CalcInputA = drive ? a : '0;
  assign CalcInputB = drive ? b : '0;
  mini_calc_cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(FW)
  ) u_fifo (
    .clk  (Clk),
    .rst  (Reset),
    .push (push),
    .pop  (pop),
    .din  ({CmdInstr, CmdA, CmdB}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  // ISSUE is one cycle, then WAIT counts CALC_LATENCY cycles; the calculator
  // result is captured on the last WAIT cycle.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cmd_n = cmd;
    res_a_n = ResA;
    res_b_n = ResB;
    res_instr_n = ResInstr;
    res_err_n = ResError;
    pop = 1'b0;
    drive = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        cmd_n = head;
        state_n = ISSUE;
      end
      ISSUE: begin
        res_instr_n = op;
        cnt_n = '0;
        drive = legal;
        state_n = legal ? WAIT : RESULT;
        res_err_n = ~legal;
        res_a_n = legal ? ResA : '0;
        res_b_n = legal ? ResB : '0;
      end
      WAIT: begin
        drive = 1'b1;
        if (cnt == CW'(CALC_LATENCY - 1)) begin
          res_a_n = CalcOutputA;
          res_b_n = CalcOutputB;
          res_err_n = 1'b0;
          state_n = RESULT;
        end else cnt_n = cnt + 1'b1;
      end
      RESULT: state_n = ResReady ? IDLE : RESULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      cmd <= '0;
      ResA <= '0;
      ResB <= '0;
      ResInstr <= NOP;
      ResError <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cmd <= cmd_n;
      ResA <= res_a_n;
      ResB <= res_b_n;
      ResInstr <= res_instr_n;
      ResError <= res_err_n;
    end
endmodule

// File: tb/tb_mini_calc_issuer.sv
// tb_mini_calc_issuer: directed scenario bench for mini_calc_issuer with a behavioural MiniCalc
module tb_mini_calc_issuer;
  import mini_calc_pkg::*;
  logic Clk = 1'b0, Reset = 1'b1, CmdValid = 1'b0, CmdReady, ResValid, ResReady = 1'b0, ResError, Busy;
  logic [3:0] CmdInstr = '0, CalcInstruction, ResInstr;
  logic [7:0] CmdA = '0, CmdB = '0, CalcInputA, CalcInputB, CalcOutputA, CalcOutputB, ResA, ResB;
  logic [15:0] prod;
  int total = 0, bad = 0;
  mini_calc_issuer dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdInstr(CmdInstr),
    .CmdA(CmdA), .CmdB(CmdB), .CalcInstruction(CalcInstruction), .CalcInputA(CalcInputA),
    .CalcInputB(CalcInputB), .CalcOutputA(CalcOutputA), .CalcOutputB(CalcOutputB),
    .ResValid(ResValid), .ResReady(ResReady), .ResA(ResA), .ResB(ResB), .ResInstr(ResInstr),
    .ResError(ResError), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  always_comb begin
    prod = {8'd0, CalcInputA} * {8'd0, CalcInputB};
    CalcOutputA = '0;
    CalcOutputB = '0;
    case (CalcInstruction)
      OP_ADD_SUB: begin
        CalcOutputA = CalcInputA + CalcInputB;
        CalcOutputB = CalcInputA - CalcInputB;
      end
      OP_MIN_MAX: begin
        CalcOutputA = CalcInputA > CalcInputB ? CalcInputA : CalcInputB;
        CalcOutputB = CalcInputA > CalcInputB ? CalcInputB : CalcInputA;
      end
      OP_MUL: begin
        CalcOutputA = prod[7:0];
        CalcOutputB = prod[15:8];
      end
      OP_DIV: if (CalcInputB != 0) begin
        CalcOutputA = CalcInputA / CalcInputB;
        CalcOutputB = CalcInputA % CalcInputB;
      end
      default: ;
    endcase
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    CmdInstr = op;
    CmdA = a;
    CmdB = b;
    CmdValid = 1'b1;
    @(posedge Clk); #1;
    CmdValid = 1'b0;
  endtask
  task automatic wait_res(output int n);
    n = 0;
    while (ResValid !== 1'b1 && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
  endtask
  task automatic take();
    ResReady = 1'b1;
    @(posedge Clk); #1;
    ResReady = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    total++; if (CmdReady !== 1'b0) begin bad++; $display("FAIL rst_cmdready got=%0d exp=0", CmdReady); end
    total++; if (ResValid !== 1'b0) begin bad++; $display("FAIL rst_resvalid got=%0d exp=0", ResValid); end
    total++; if (ResA !== 8'd0 || ResB !== 8'd0) begin bad++; $display("FAIL rst_res got=%0d,%0d exp=0,0", ResA, ResB); end
    total++; if (ResInstr !== 4'hF || ResError !== 1'b0) begin bad++; $display("FAIL rst_instr got=%0h,%0d exp=f,0", ResInstr, ResError); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", Busy); end
    total++; if (CalcInstruction !== 4'hF || CalcInputA !== 8'd0 || CalcInputB !== 8'd0) begin bad++; $display("FAIL rst_calc got=%0h,%0d,%0d exp=f,0,0", CalcInstruction, CalcInputA, CalcInputB); end
    Reset = 1'b0;
    @(posedge Clk); #1;
    total++; if (CmdReady !== 1'b1) begin bad++; $display("FAIL post_rst_cmdready got=%0d exp=1", CmdReady); end
  endtask
  task automatic test_add_sub();
    int n;
    logic drove;
    ResReady = 1'b0;
    push(OP_ADD_SUB, 8'd6, 8'd3);
    n = 0;
    drove = 1'b0;
    while (ResValid !== 1'b1 && n < 50) begin
      @(posedge Clk); #1;
      n++;
      if (CalcInstruction === OP_ADD_SUB && CalcInputA === 8'd6 && CalcInputB === 8'd3) drove = 1'b1;
    end
    total++; if (n != 4) begin bad++; $display("FAIL add_latency got=%0d exp=4 edges after push", n); end
    total++; if (drove !== 1'b1) begin bad++; $display("FAIL add_calc_drive got=%0d exp=1", drove); end
    total++; if (ResA !== 8'd9 || ResB !== 8'd3) begin bad++; $display("FAIL add1_res got=%0d,%0d exp=9,3", ResA, ResB); end
    total++; if (ResInstr !== OP_ADD_SUB || ResError !== 1'b0) begin bad++; $display("FAIL add1_instr got=%0h,%0d exp=7,0", ResInstr, ResError); end
    total++; if (CalcInstruction !== 4'hF || CalcInputA !== 8'd0) begin bad++; $display("FAIL add_calc_idle got=%0h,%0d exp=f,0", CalcInstruction, CalcInputA); end
    take();
    total++; if (ResValid !== 1'b0) begin bad++; $display("FAIL add_release got=%0d exp=0", ResValid); end
    push(OP_ADD_SUB, 8'd8, 8'd5);
    wait_res(n);
    total++; if (n != 4) begin bad++; $display("FAIL add2_latency got=%0d exp=4", n); end
    total++; if (ResA !== 8'd13 || ResB !== 8'd3) begin bad++; $display("FAIL add2_res got=%0d,%0d exp=13,3", ResA, ResB); end
    take();
  endtask
  task automatic test_sequence();
    logic [3:0] op [4] = '{OP_MIN_MAX, OP_MUL, OP_DIV, OP_NOP};
    logic [7:0] a [4] = '{8'd3, 8'd6, 8'd15, 8'd6};
    logic [7:0] b [4] = '{8'd11, 8'd3, 8'd2, 8'd3};
    logic [7:0] ea [4] = '{8'd11, 8'd18, 8'd7, 8'd0};
    logic [7:0] eb [4] = '{8'd3, 8'd0, 8'd1, 8'd0};
    int n;
    for (int i = 0; i < 4; i++) push(op[i], a[i], b[i]);
    for (int i = 0; i < 4; i++) begin
      wait_res(n);
      total++; if (n >= 50) begin bad++; $display("FAIL seq%0d_timeout got=%0d exp=<50", i, n); end
      total++; if (ResA !== ea[i] || ResB !== eb[i]) begin bad++; $display("FAIL seq%0d_res got=%0d,%0d exp=%0d,%0d", i, ResA, ResB, ea[i], eb[i]); end
      total++; if (ResInstr !== op[i] || ResError !== 1'b0) begin bad++; $display("FAIL seq%0d_instr got=%0h,%0d exp=%0h,0", i, ResInstr, ResError, op[i]); end
      take();
    end
  endtask
  task automatic test_illegal();
    int n;
    logic calc_ok;
    push(4'b0000, 8'd1, 8'd2);
    n = 0;
    calc_ok = 1'b1;
    while (ResValid !== 1'b1 && n < 50) begin
      @(posedge Clk); #1;
      n++;
      if (CalcInstruction !== 4'hF || CalcInputA !== 8'd0 || CalcInputB !== 8'd0) calc_ok = 1'b0;
    end
    total++; if (n != 2) begin bad++; $display("FAIL ill_latency got=%0d exp=2", n); end
    total++; if (calc_ok !== 1'b1) begin bad++; $display("FAIL ill_calc_driven got=%0d exp=1", calc_ok); end
    total++; if (ResError !== 1'b1 || ResA !== 8'd0 || ResB !== 8'd0) begin bad++; $display("FAIL ill_res got=%0d,%0d,%0d exp=1,0,0", ResError, ResA, ResB); end
    total++; if (ResInstr !== 4'h0) begin bad++; $display("FAIL ill_instr got=%0h exp=0", ResInstr); end
    take();
  endtask
  task automatic test_hold();
    int n;
    push(OP_MUL, 8'd7, 8'd9);
    wait_res(n);
    total++; if (n != 4) begin bad++; $display("FAIL hold_latency got=%0d exp=4", n); end
    for (int i = 0; i < 10; i++) begin
      total++; if (ResValid !== 1'b1) begin bad++; $display("FAIL hold%0d_valid got=%0d exp=1", i, ResValid); end
      total++; if (ResA !== 8'd63 || ResB !== 8'd0 || ResInstr !== OP_MUL) begin bad++; $display("FAIL hold%0d_payload got=%0d,%0d,%0h exp=63,0,d", i, ResA, ResB, ResInstr); end
      @(posedge Clk); #1;
    end
    take();
  endtask
  task automatic test_back_to_back();
    int n;
    logic extra;
    ResReady = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      total++; if (CmdReady !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%0d exp=1", k, CmdReady); end
      push(OP_ADD_SUB, 8'(k), 8'(k));
    end
    repeat (3) @(posedge Clk);
    #1;
    total++; if (CmdReady !== 1'b0) begin bad++; $display("FAIL b2b_full got=%0d exp=0", CmdReady); end
    CmdInstr = OP_ADD_SUB;
    CmdA = 8'd99;
    CmdB = 8'd1;
    CmdValid = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    ResReady = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_res(n);
      total++; if (n >= 50) begin bad++; $display("FAIL b2b%0d_timeout got=%0d exp=<50", k, n); end
      total++; if (ResA !== 8'(2 * k) || ResB !== 8'd0) begin bad++; $display("FAIL b2b%0d_res got=%0d,%0d exp=%0d,0", k, ResA, ResB, 2 * k); end
      @(posedge Clk); #1;
    end
    extra = 1'b0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (ResValid === 1'b1) extra = 1'b1;
    end
    ResReady = 1'b0;
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL b2b_extra_result got=%0d exp=0", extra); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%0d exp=0", Busy); end
  endtask
  task automatic test_reset_mid();
    logic seen, busy;
    ResReady = 1'b0;
    push(OP_ADD_SUB, 8'd1, 8'd2);
    push(OP_ADD_SUB, 8'd3, 8'd4);
    push(OP_ADD_SUB, 8'd5, 8'd6);
    total++; if (CalcInstruction !== OP_ADD_SUB || ResValid !== 1'b0) begin bad++; $display("FAIL mid_in_wait got=%0h,%0d exp=7,0", CalcInstruction, ResValid); end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%0d exp=1", Busy); end
    Reset = 1'b1;
    #1;
    total++; if (CmdReady !== 1'b0 || ResValid !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=%0d,%0d,%0d exp=0,0,0", CmdReady, ResValid, Busy); end
    total++; if (ResA !== 8'd0 || ResB !== 8'd0 || ResInstr !== 4'hF || ResError !== 1'b0) begin bad++; $display("FAIL mid_rst_res got=%0d,%0d,%0h,%0d exp=0,0,f,0", ResA, ResB, ResInstr, ResError); end
    total++; if (CalcInstruction !== 4'hF || CalcInputA !== 8'd0 || CalcInputB !== 8'd0) begin bad++; $display("FAIL mid_rst_calc got=%0h,%0d,%0d exp=f,0,0", CalcInstruction, CalcInputA, CalcInputB); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    ResReady = 1'b1;
    seen = 1'b0;
    busy = 1'b0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (ResValid === 1'b1) seen = 1'b1;
      if (Busy === 1'b1) busy = 1'b1;
    end
    ResReady = 1'b0;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_result_after_rst got=%0d exp=0", seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after_rst got=%0d exp=0", busy); end
    total++; if (CmdReady !== 1'b1) begin bad++; $display("FAIL mid_ready_after_rst got=%0d exp=1", CmdReady); end
  endtask
  initial begin
    test_reset();
    test_add_sub();
    test_sequence();
    test_illegal();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
